// File: rtl/spell_ram_arbiter_pkg.sv
// Shared spell definitions: rambus memory widths, requester indices and
// the arbiter state encoding.
package spell_ram_arbiter_pkg;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_SEL_W  = 4;
    localparam int NUM_REQ    = 2;

    localparam int REQ_CORE = 0;
    localparam int REQ_HOST = 1;

    localparam logic [RAM_DATA_W-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/spell_ram_arbiter.sv
// Two-requester round-robin arbiter for the shared spell RAM: one transfer per
// grant, with abort on cyc drop and an optional watchdog that force-acks.
module spell_ram_arbiter
    import spell_ram_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              m_wb_cyc_i,
    input  logic [NUM_REQ-1:0]              m_wb_stb_i,
    input  logic [NUM_REQ-1:0]              m_wb_we_i,
    input  logic [NUM_REQ*RAM_SEL_W-1:0]    m_wb_sel_i,
    input  logic [NUM_REQ*RAM_DATA_W-1:0]   m_wb_dat_i,
    input  logic [NUM_REQ*RAM_ADDR_W-1:0]   m_wb_addr_i,
    output logic [NUM_REQ-1:0]              m_wb_ack_o,
    output logic [RAM_DATA_W-1:0]           m_wb_dat_o,
    output logic                            rambus_wb_cyc_o,
    output logic                            rambus_wb_stb_o,
    output logic                            rambus_wb_we_o,
    output logic [RAM_SEL_W-1:0]            rambus_wb_sel_o,
    output logic [RAM_DATA_W-1:0]           rambus_wb_dat_o,
    output logic [RAM_ADDR_W-1:0]           rambus_wb_addr_o,
    input  logic                            rambus_wb_ack_i,
    input  logic [RAM_DATA_W-1:0]           rambus_wb_dat_i,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic                            timeout_o
);

    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_e          state_p0, state_d;
    logic [NUM_REQ-1:0]  grant_p0, grant_d;
    logic                last_p0, last_d;
    logic [7:0]          cnt_p0, cnt_d;

    logic [NUM_REQ-1:0]  req;
    logic                busy;
    logic                gnt_idx;
    logic                gnt_cyc;
    logic                gnt_req;
    logic                to_hit;
    logic                abort;
    logic                pick_host;

    assign req     = m_wb_cyc_i & m_wb_stb_i;
    assign busy    = (state_p0 == ST_BUSY);
    assign gnt_idx = grant_p0[REQ_HOST];
    assign gnt_cyc = m_wb_cyc_i[gnt_idx];
    assign gnt_req = req[gnt_idx];

    // A downstream ack in the timeout cycle takes precedence over the watchdog.
    assign to_hit = busy && TO_EN && (cnt_p0 == TO_LAST) && !rambus_wb_ack_i && gnt_cyc;
    assign abort  = busy && !gnt_cyc && !rambus_wb_ack_i;

    // With both requesting, the one not served last wins.
    assign pick_host = req[REQ_HOST] && (!req[REQ_CORE] || !last_p0);

    // ---- stage p0: arbitration state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_p0 <= ST_IDLE;
            grant_p0 <= '0;
            last_p0  <= 1'b1;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_d;
            grant_p0 <= grant_d;
            last_p0  <= last_d;
            cnt_p0   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_p0;
        grant_d = grant_p0;
        last_d  = last_p0;
        cnt_d   = cnt_p0;
        case (state_p0)
            ST_IDLE: begin
                cnt_d = '0;
                if (req != '0) begin
                    state_d = ST_BUSY;
                    grant_d = '0;
                    if (pick_host) grant_d[REQ_HOST] = 1'b1;
                    else           grant_d[REQ_CORE] = 1'b1;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_p0 + 8'd1;
                if (rambus_wb_ack_i || to_hit) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = gnt_idx;
                    cnt_d   = '0;
                end else if (abort) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are masked while reset is high so nothing pulses during reset.
    always_comb begin
        rambus_wb_cyc_o  = 1'b0;
        rambus_wb_stb_o  = 1'b0;
        rambus_wb_we_o   = 1'b0;
        rambus_wb_sel_o  = '0;
        rambus_wb_dat_o  = '0;
        rambus_wb_addr_o = '0;
        m_wb_ack_o       = '0;
        m_wb_dat_o       = rambus_wb_dat_i;
        timeout_o        = 1'b0;
        grant_o          = reset ? '0 : grant_p0;
        if (!reset && busy) begin
            rambus_wb_cyc_o  = gnt_req;
            rambus_wb_stb_o  = gnt_req;
            rambus_wb_we_o   = gnt_req & m_wb_we_i[gnt_idx];
            if (gnt_req) begin
                rambus_wb_sel_o  = gnt_idx ? m_wb_sel_i[2*RAM_SEL_W-1:RAM_SEL_W]
                                           : m_wb_sel_i[RAM_SEL_W-1:0];
                rambus_wb_dat_o  = gnt_idx ? m_wb_dat_i[2*RAM_DATA_W-1:RAM_DATA_W]
                                           : m_wb_dat_i[RAM_DATA_W-1:0];
                rambus_wb_addr_o = gnt_idx ? m_wb_addr_i[2*RAM_ADDR_W-1:RAM_ADDR_W]
                                           : m_wb_addr_i[RAM_ADDR_W-1:0];
            end
            m_wb_ack_o[gnt_idx] = rambus_wb_ack_i | to_hit;
            if (to_hit) begin
                rambus_wb_cyc_o = 1'b0;
                rambus_wb_stb_o = 1'b0;
                timeout_o       = 1'b1;
                m_wb_dat_o      = TIMEOUT_DATA;
            end
        end
    end

endmodule

// File: tb/tb_spell_ram_arbiter.sv
// Directed bench for spell_ram_arbiter: inputs change and outputs are checked
// just after the falling edge, so the rising edge samples settled values.
module tb_spell_ram_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  m_wb_cyc_i;
    logic [1:0]  m_wb_stb_i;
    logic [1:0]  m_wb_we_i;
    logic [7:0]  m_wb_sel_i;
    logic [63:0] m_wb_dat_i;
    logic [15:0] m_wb_addr_i;
    logic [1:0]  m_wb_ack_o;
    logic [31:0] m_wb_dat_o;
    logic        rambus_wb_cyc_o;
    logic        rambus_wb_stb_o;
    logic        rambus_wb_we_o;
    logic [3:0]  rambus_wb_sel_o;
    logic [31:0] rambus_wb_dat_o;
    logic [7:0]  rambus_wb_addr_o;
    logic        rambus_wb_ack_i;
    logic [31:0] rambus_wb_dat_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    spell_ram_arbiter #(.TIMEOUT(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .m_wb_cyc_i      (m_wb_cyc_i),
        .m_wb_stb_i      (m_wb_stb_i),
        .m_wb_we_i       (m_wb_we_i),
        .m_wb_sel_i      (m_wb_sel_i),
        .m_wb_dat_i      (m_wb_dat_i),
        .m_wb_addr_i     (m_wb_addr_i),
        .m_wb_ack_o      (m_wb_ack_o),
        .m_wb_dat_o      (m_wb_dat_o),
        .rambus_wb_cyc_o (rambus_wb_cyc_o),
        .rambus_wb_stb_o (rambus_wb_stb_o),
        .rambus_wb_we_o  (rambus_wb_we_o),
        .rambus_wb_sel_o (rambus_wb_sel_o),
        .rambus_wb_dat_o (rambus_wb_dat_o),
        .rambus_wb_addr_o(rambus_wb_addr_o),
        .rambus_wb_ack_i (rambus_wb_ack_i),
        .rambus_wb_dat_i (rambus_wb_dat_i),
        .grant_o         (grant_o),
        .timeout_o       (timeout_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        m_wb_cyc_i      = 2'b00;
        m_wb_stb_i      = 2'b00;
        m_wb_we_i       = 2'b00;
        m_wb_sel_i      = 8'h00;
        m_wb_dat_i      = 64'h0;
        m_wb_addr_i     = 16'h0;
        rambus_wb_ack_i = 1'b0;
        rambus_wb_dat_i = 32'h0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        m_wb_cyc_i = 2'b11;
        m_wb_stb_i = 2'b11;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
        checks++; if ({rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o} !== 3'b000) begin errors++; $display("FAIL reset_rambus_ctl: got %b expected 000", {rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o}); end
        checks++; if ({m_wb_ack_o, timeout_o} !== 3'b000) begin errors++; $display("FAIL reset_ack_timeout: got %b expected 000", {m_wb_ack_o, timeout_o}); end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clock);
        m_wb_cyc_i  = 2'b01;  m_wb_stb_i = 2'b01;  m_wb_we_i = 2'b01;
        m_wb_sel_i  = 8'h3F;
        m_wb_dat_i  = {32'h5555_AAAA, 32'hDEAD_BEEF};
        m_wb_addr_i = {8'h77, 8'h12};
        #1;
        checks++; if (rambus_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL write_latency: rambus cyc got %b expected 0", rambus_wb_cyc_o); end
        @(negedge clock); #1;
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL write_grant: got %b expected 01", grant_o); end
        checks++; if (rambus_wb_addr_o !== 8'h12) begin errors++; $display("FAIL write_addr: got %h expected 12", rambus_wb_addr_o); end
        checks++; if (rambus_wb_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_data: got %h expected deadbeef", rambus_wb_dat_o); end
        checks++; if ({rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o, rambus_wb_sel_o} !== 7'b111_1111) begin errors++; $display("FAIL write_ctl: got %b expected 1111111", {rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o, rambus_wb_sel_o}); end
        @(negedge clock);
        rambus_wb_ack_i = 1'b1;
        #1;
        checks++; if (m_wb_ack_o !== 2'b01) begin errors++; $display("FAIL write_ack: got %b expected 01", m_wb_ack_o); end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL write_release: grant got %b expected 00", grant_o); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt [4];
        logic [7:0] exp_addr [4];
        exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_addr = '{8'h10, 8'h21, 8'h10, 8'h21};
        apply_reset();
        m_wb_cyc_i  = 2'b11;  m_wb_stb_i = 2'b11;
        m_wb_addr_i = {8'h21, 8'h10};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            rambus_wb_ack_i = 1'b1;
            rambus_wb_dat_i = 32'h1000_0000 + i;
            #1;
            checks++; if (grant_o !== exp_gnt[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, grant_o, exp_gnt[i]); end
            checks++; if (rambus_wb_addr_o !== exp_addr[i]) begin errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", i, rambus_wb_addr_o, exp_addr[i]); end
            checks++; if (m_wb_ack_o !== exp_gnt[i]) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, m_wb_ack_o, exp_gnt[i]); end
            checks++; if (m_wb_dat_o !== 32'h1000_0000 + i) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", i, m_wb_dat_o, 32'h1000_0000 + i); end
            @(negedge clock);
            rambus_wb_ack_i = 1'b0;
            if (i == 3) idle_inputs();
            #1;
            checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rr_idle_gap[%0d]: got %b expected 00", i, grant_o); end
        end
    endtask

    task automatic test_timeout();
        @(negedge clock);
        m_wb_cyc_i  = 2'b10;  m_wb_stb_i = 2'b10;  m_wb_we_i = 2'b00;
        m_wb_addr_i = {8'h40, 8'h00};
        rambus_wb_dat_i = 32'h1234_5678;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock); #1;
            if (k == 1) begin
                checks++; if ({grant_o, rambus_wb_addr_o, rambus_wb_we_o} !== {2'b10, 8'h40, 1'b0}) begin errors++; $display("FAIL to_read_setup: got %b/%h/%b expected 10/40/0", grant_o, rambus_wb_addr_o, rambus_wb_we_o); end
            end
            if (k < 16) begin
                checks++; if ({m_wb_ack_o, timeout_o} !== 3'b000) begin errors++; $display("FAIL to_early[%0d]: ack/timeout got %b expected 000", k, {m_wb_ack_o, timeout_o}); end
            end else begin
                checks++; if (m_wb_ack_o !== 2'b10) begin errors++; $display("FAIL to_ack: got %b expected 10", m_wb_ack_o); end
                checks++; if (m_wb_dat_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_data: got %h expected ffffffff", m_wb_dat_o); end
                checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout_o); end
                checks++; if ({rambus_wb_cyc_o, rambus_wb_stb_o} !== 2'b00) begin errors++; $display("FAIL to_drop: cyc/stb got %b expected 00", {rambus_wb_cyc_o, rambus_wb_stb_o}); end
            end
        end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if ({grant_o, timeout_o} !== 3'b000) begin errors++; $display("FAIL to_after: grant/timeout got %b expected 000", {grant_o, timeout_o}); end
    endtask

    task automatic test_ack_timeout_coincide();
        @(negedge clock);
        m_wb_cyc_i  = 2'b10;  m_wb_stb_i = 2'b10;
        m_wb_addr_i = {8'h41, 8'h00};
        repeat (15) @(negedge clock);
        @(negedge clock);
        rambus_wb_ack_i = 1'b1;
        rambus_wb_dat_i = 32'hCAFE_F00D;
        #1;
        checks++; if (m_wb_ack_o !== 2'b10) begin errors++; $display("FAIL tie_ack: got %b expected 10", m_wb_ack_o); end
        checks++; if (m_wb_dat_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL tie_data: got %h expected cafef00d", m_wb_dat_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL tie_timeout: got %b expected 0", timeout_o); end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL tie_release: got %b expected 00", grant_o); end
    endtask

    task automatic test_abort();
        @(negedge clock);
        m_wb_cyc_i  = 2'b01;  m_wb_stb_i = 2'b01;
        m_wb_addr_i = {8'h99, 8'h05};
        @(negedge clock); #1;
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL abort_grant0: got %b expected 01", grant_o); end
        m_wb_cyc_i = 2'b10;  m_wb_stb_i = 2'b10;
        #1;
        checks++; if ({m_wb_ack_o, rambus_wb_cyc_o} !== 3'b000) begin errors++; $display("FAIL abort_no_ack: ack/cyc got %b expected 000", {m_wb_ack_o, rambus_wb_cyc_o}); end
        @(negedge clock); #1;
        checks++; if ({grant_o, m_wb_ack_o} !== 4'b0000) begin errors++; $display("FAIL abort_idle: grant/ack got %b expected 0000", {grant_o, m_wb_ack_o}); end
        @(negedge clock); #1;
        checks++; if ({grant_o, rambus_wb_addr_o} !== {2'b10, 8'h99}) begin errors++; $display("FAIL abort_grant1: got %b/%h expected 10/99", grant_o, rambus_wb_addr_o); end
        rambus_wb_ack_i = 1'b1;
        #1;
        checks++; if (m_wb_ack_o !== 2'b10) begin errors++; $display("FAIL abort_ack1: got %b expected 10", m_wb_ack_o); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_reset_mid_transfer();
        // Serve m0 once so that only a reset can make m0 win the next tie.
        @(negedge clock);
        m_wb_cyc_i  = 2'b01;  m_wb_stb_i = 2'b01;
        m_wb_addr_i = {8'h66, 8'h33};
        @(negedge clock);
        rambus_wb_ack_i = 1'b1;
        @(negedge clock);
        rambus_wb_ack_i = 1'b0;
        @(negedge clock); #1;
        checks++; if ({grant_o, rambus_wb_cyc_o} !== 3'b011) begin errors++; $display("FAIL rst_mid_busy: grant/cyc got %b expected 011", {grant_o, rambus_wb_cyc_o}); end
        reset = 1'b1;
        m_wb_cyc_i = 2'b11;  m_wb_stb_i = 2'b11;
        rambus_wb_ack_i = 1'b1;
        #1;
        checks++; if ({grant_o, m_wb_ack_o, rambus_wb_cyc_o, rambus_wb_stb_o} !== 6'b0) begin errors++; $display("FAIL rst_mid_glitch: got %b expected 000000", {grant_o, m_wb_ack_o, rambus_wb_cyc_o, rambus_wb_stb_o}); end
        @(negedge clock); #1;
        checks++; if ({grant_o, m_wb_ack_o, rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o} !== 7'b0) begin errors++; $display("FAIL rst_mid_outputs: got %b expected 0000000", {grant_o, m_wb_ack_o, rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o}); end
        checks++; if ({rambus_wb_addr_o, rambus_wb_sel_o} !== 12'h000) begin errors++; $display("FAIL rst_mid_bus: addr/sel got %h expected 000", {rambus_wb_addr_o, rambus_wb_sel_o}); end
        reset = 1'b0;
        rambus_wb_ack_i = 1'b0;
        @(negedge clock); #1;
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rst_first_grant: got %b expected 01", grant_o); end
        rambus_wb_ack_i = 1'b1;
        #1;
        checks++; if (m_wb_ack_o !== 2'b01) begin errors++; $display("FAIL rst_first_ack: got %b expected 01", m_wb_ack_o); end
        @(negedge clock);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_timeout();
        test_ack_timeout_coincide();
        test_abort();
        test_reset_mid_transfer();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spell_ram_arbiter.md
SPELL_RAM_ARBITER -- requirements
Module: spell_ram_arbiter

Interface
REQ-001: Parameter TIMEOUT, default 16: cycles without ack before a granted transfer is force-terminated; 0 disables the timeout; legal range 0..255.
REQ-002: Clocking and reset SHALL be one clock with synchronous, active-high reset: clock  input  1  system clock; reset  input  1  synchronous active-high reset.
REQ-003: m_wb_cyc_i  input  2  cycle per requester; bit n belongs to requester n (0 = spell core, 1 = host loader).
REQ-004: m_wb_stb_i  input  2  strobe per requester.
REQ-005: m_wb_we_i  input  2  write enable per requester.
REQ-006: m_wb_sel_i  input  8  byte select, 4 bits per requester, requester n at [4n+3:4n].
REQ-007: m_wb_dat_i  input  64  write data, 32 bits per requester.
REQ-008: m_wb_addr_i  input  16  word address, 8 bits per requester.
REQ-009: m_wb_ack_o  output  2  per-requester ack.
REQ-010: m_wb_dat_o  output  32  read data, shared by both requesters.
REQ-011: rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o  output  1 each  downstream shared-RAM controls.
REQ-012: rambus_wb_sel_o  output  4;  rambus_wb_dat_o  output  32;  rambus_wb_addr_o  output  8.
REQ-013: rambus_wb_ack_i  input  1;  rambus_wb_dat_i  input  32  downstream response.
REQ-014: grant_o  output  2  one-hot current owner, 0 when idle;  timeout_o  output  1  one-cycle pulse on forced termination.

Function
REQ-015: States: IDLE, BUSY; the FSM SHALL leave IDLE only when at least one requester has cyc&stb high.
REQ-016: In IDLE with exactly one request, that requester SHALL be granted; with both requesting, the requester not granted last SHALL win (round-robin, last-grant flag resets to 1 so requester 0 wins first).
REQ-017: Arbitration latency: grant registered; BUSY and grant_o valid the cycle after the request is sampled.
REQ-018: In BUSY, rambus cyc/stb/we/sel/dat/addr SHALL combinationally follow the granted requester, gated by its cyc&stb; all rambus outputs 0 in IDLE.
REQ-019: rambus_wb_ack_i SHALL route combinationally to the granted requester's ack only; the other ack SHALL stay 0; m_wb_dat_o = rambus_wb_dat_i at all times.
REQ-020: On ack the FSM SHALL return to IDLE (one transfer per grant; at least one idle bus cycle between grants) and update the last-grant flag.
REQ-021: If the granted requester drops cyc in BUSY without ack, the FSM SHALL return to IDLE next cycle with no ack issued (abort).
REQ-022: Timeout counter (8-bit, cleared on entry to BUSY) SHALL increment each BUSY cycle without ack; when it reaches TIMEOUT-1 with TIMEOUT!=0, the arbiter SHALL assert the granted ack with m_wb_dat_o = 32'hFFFF_FFFF, pulse timeout_o, drop rambus cyc/stb, and return to IDLE.
REQ-023: Ack arriving in the same cycle as the timeout SHALL win: normal ack and data, no timeout_o.
REQ-024: A request arriving during BUSY SHALL be held pending and served from IDLE; no request SHALL ever be dropped.

Reset
REQ-025: Reset SHALL force IDLE, grant_o=0, last-grant=1, counter=0, timeout_o=0, all acks and rambus outputs 0 from the next edge, including mid-transfer.
REQ-026: No output SHALL glitch high during the reset cycle.

Structure
REQ-027: State encoding and requester index constants SHALL live in the shared spell package alongside the memory-type defines.
REQ-028: Single module; no sub-module; instantiated between spell_mem's SRAM port, the host loader and the top-level rambus pins.

Verification
REQ-029: Only m0 writes addr 0x12, data 0xDEADBEEF, sel 0xF -> grant_o=01 next cycle, rambus_wb_addr_o=0x12, dat_o=0xDEADBEEF; ack after 2 cycles reaches m_wb_ack_o[0] only.
REQ-030: Both request continuously, ack after 1 cycle each -> grants sequence 01,10,01,10 with one idle cycle between.
REQ-031: m1 reads addr 0x40, no downstream ack, TIMEOUT=16 -> 16th BUSY cycle: m_wb_ack_o[1]=1, m_wb_dat_o=0xFFFFFFFF, timeout_o one cycle.
REQ-032: Ack and timeout coincide on cycle 16 -> normal data returned, timeout_o stays 0.
REQ-033: m0 granted, drops cyc before ack while m1 requests -> IDLE next cycle, m1 granted following cycle, no ack to m0.
REQ-034: Reset asserted mid-transfer -> next cycle all rambus outputs 0, grant_o=0; after release, simultaneous requests grant m0 first.
